fetch_unit: RTL

Instruction fetch sequencer that sits directly downstream of program_counter. It requests the PC value, drives it to memory as a read address, and waits on a memory ready handshake. It then latches the returned word into the instruction register, pulses the PC increment, and presents the instruction to the decoder under a valid/ack handshake. Instructions flagged as carrying an immediate get a second word fetched into a separate immediate register before valid is raised.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 80 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: PC request/increment, memory read handshake and
// decoder valid/ack. The fetch unit is the master side.
interface fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] pc_value;
    logic                  pc_read;
    logic                  pc_inc;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] imm;
    logic                  ir_valid;
    logic                  ir_ack;

    modport master (
        input  pc_value, mem_ready, mem_data, ir_ack,
        output pc_read, pc_inc, mem_addr, mem_read, ir, imm, ir_valid
    );

    modport slave (
        output pc_value, mem_ready, mem_data, ir_ack,
        input  pc_read, pc_inc, mem_addr, mem_read, ir, imm, ir_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads PC, fetches one or two words from memory,
// bumps the PC per word and hands the instruction to the decoder.
module fetch_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IMM_BIT    = 15
) (
    input  logic         clk,
    input  logic         notClr,
    input  logic         halt,
    output logic         busy,
    fetch_unit_if.master bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StMem   = 3'd2;
    localparam logic [2:0] StInc   = 3'd3;
    localparam logic [2:0] StValid = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  imm_pending_q, imm_pending_d;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] imm_q;

    always_comb begin
        state_d       = state_q;
        imm_pending_d = imm_pending_q;
        case (state_q)
            StIdle:  if (!halt) state_d = StAddr;
            StAddr:  state_d = StMem;
            StMem:   if (bus.mem_ready) state_d = StInc;
            StInc: begin
                // Only the first word can request a trailing immediate
                if (!imm_pending_q && ir_q[IMM_BIT]) begin
                    imm_pending_d = 1'b1;
                    state_d       = StAddr;
                end else begin
                    imm_pending_d = 1'b0;
                    state_d       = StValid;
                end
            end
            StValid: if (bus.ir_ack) state_d = halt ? StIdle : StAddr;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge notClr) begin
        if (!notClr) begin
            state_q       <= StIdle;
            imm_pending_q <= 1'b0;
            mem_addr_q    <= '0;
            ir_q          <= '0;
            imm_q         <= '0;
        end else begin
            state_q       <= state_d;
            imm_pending_q <= imm_pending_d;
            if (state_q == StAddr) begin
                mem_addr_q <= bus.pc_value;
            end
            if (state_q == StMem && bus.mem_ready) begin
                if (imm_pending_q) begin
                    imm_q <= bus.mem_data;
                end else begin
                    ir_q <= bus.mem_data;
                end
            end
        end
    end

    assign bus.pc_read  = (state_q == StAddr);
    assign bus.mem_read = (state_q == StMem);
    assign bus.pc_inc   = (state_q == StInc);
    assign bus.ir_valid = (state_q == StValid);
    assign bus.mem_addr = mem_addr_q;
    assign bus.ir       = ir_q;
    assign bus.imm      = imm_q;
    assign busy         = (state_q != StIdle);

endmodule
